// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code decoder.
//   key_event_t  - {brk, ext, code[7:0]} event word
//   dec_state_t  - decoder sequence state
//   byte constants for the set-2 prefixes and keyboard control responses
package ps2_pkg;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

    localparam int KEY_EVENT_W = $bits(key_event_t);

    localparam logic [7:0] PREFIX_E0 = 8'hE0;
    localparam logic [7:0] PREFIX_F0 = 8'hF0;
    localparam logic [7:0] PREFIX_E1 = 8'hE1;

    // Keyboard-to-host control responses; these never form part of a key sequence.
    localparam logic [7:0] CTL_ERR0     = 8'h00;
    localparam logic [7:0] CTL_BAT_OK   = 8'hAA;
    localparam logic [7:0] CTL_ECHO     = 8'hEE;
    localparam logic [7:0] CTL_ACK      = 8'hFA;
    localparam logic [7:0] CTL_BAT_ERR0 = 8'hFC;
    localparam logic [7:0] CTL_BAT_ERR1 = 8'hFD;
    localparam logic [7:0] CTL_RESEND   = 8'hFE;
    localparam logic [7:0] CTL_ERR1     = 8'hFF;

    // Pause is reported as extended 77, a combination set 2 never uses otherwise.
    localparam logic [7:0] PAUSE_CODE = 8'h77;
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_PAUSE
    } dec_state_t;

    function automatic logic is_ctl_byte(input logic [7:0] b);
        logic hit;
        case (b)
            CTL_ERR0, CTL_BAT_OK, CTL_ECHO, CTL_ACK,
            CTL_BAT_ERR0, CTL_BAT_ERR1, CTL_RESEND, CTL_ERR1: hit = 1'b1;
            default:                                          hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic key_event_t make_event(input logic brk, input logic ext,
                                              input logic [7:0] code);
        key_event_t ev;
        ev.brk  = brk;
        ev.ext  = ext;
        ev.code = code;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word fall-through FIFO with valid/ready style control.
//   sysclk     - clock
//   reset      - synchronous active-high reset
//   push       - write push_data (ignored when full unless a pop happens too)
//   push_data  - entry to write
//   pop        - remove the head entry (ignored when empty)
//   head_data  - current head entry, combinationally visible
//   empty/full - occupancy flags
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic do_pop;
    logic do_push;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot the write pointer addresses, so the write can proceed.
    assign do_push = push && (!full || do_pop);

    assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
                wr_ptr_reg                  <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: assembles PS/2 scan-code-set-2 byte sequences into key
// events and separates keyboard control responses from key traffic.
//   sysclk     - system clock
//   reset      - synchronous active-high reset
//   word/done  - received byte and its one-cycle valid strobe
//   ev_data    - head event {brk, ext, code}
//   ev_valid   - event FIFO non-empty
//   ev_ready   - consumer accepts the head event
//   ctl_strobe - one-cycle pulse after a control byte arrives
//   ctl_byte   - last control byte, held until the next strobe
//   overflow   - sticky: an event was dropped because the FIFO was full
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  word,
    input  logic        done,
    output logic [9:0]  ev_data,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic        ctl_strobe,
    output logic [7:0]  ctl_byte,
    output logic        overflow
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    dec_state_t  state_reg;
    logic [2:0]  pause_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic        ctl_strobe_reg;
    logic [7:0]  ctl_byte_reg;
    logic        overflow_reg;

    logic        byte_ctl;
    logic        byte_prefix;
    logic        push;
    key_event_t  push_event;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;

    assign byte_ctl    = is_ctl_byte(word);
    assign byte_prefix = (word == PREFIX_E0) || (word == PREFIX_F0) || (word == PREFIX_E1);

    // Event generation is combinational from the registered state so the FIFO
    // captures the event on the same edge that consumes the final byte.
    always_comb begin
        push       = 1'b0;
        push_event = make_event(1'b0, 1'b0, word);
        if (done && !reset && !byte_ctl) begin
            if (state_reg == ST_PAUSE) begin
                // Pause tail bytes are skipped blindly; the last one emits the event.
                if (pause_cnt_reg == 3'd1) begin
                    push       = 1'b1;
                    push_event = make_event(1'b0, 1'b1, PAUSE_CODE);
                end
            end else if (!byte_prefix) begin
                push = 1'b1;
                case (state_reg)
                    ST_E0:   push_event = make_event(1'b0, 1'b1, word);
                    ST_F0:   push_event = make_event(1'b1, 1'b0, word);
                    ST_E0F0: push_event = make_event(1'b1, 1'b1, word);
                    default: push_event = make_event(1'b0, 1'b0, word);
                endcase
            end
        end
    end

    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready;

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_EVENT_W)
    ) u_fifo (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (push),
        .push_data (push_event),
        .pop       (pop),
        .head_data (ev_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            pause_cnt_reg  <= '0;
            tmo_cnt_reg    <= '0;
            ctl_strobe_reg <= 1'b0;
            ctl_byte_reg   <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            ctl_strobe_reg <= 1'b0;

            if (push && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end

            if (done) begin
                // A byte always wins over a timeout expiring on the same cycle.
                tmo_cnt_reg <= '0;
                if (byte_ctl) begin
                    ctl_strobe_reg <= 1'b1;
                    ctl_byte_reg   <= word;
                    state_reg      <= ST_IDLE;
                end else if (state_reg == ST_PAUSE) begin
                    pause_cnt_reg <= pause_cnt_reg - 3'd1;
                    if (pause_cnt_reg == 3'd1) begin
                        state_reg <= ST_IDLE;
                    end
                end else begin
                    case (word)
                        PREFIX_E0: state_reg <= ST_E0;
                        // F0 after E0 completes the extended-break prefix; after
                        // F0 or E0F0 it restarts a plain break.
                        PREFIX_F0: state_reg <= (state_reg == ST_E0) ? ST_E0F0 : ST_F0;
                        PREFIX_E1: begin
                            state_reg     <= ST_PAUSE;
                            pause_cnt_reg <= PAUSE_TAIL;
                        end
                        default:   state_reg <= ST_IDLE;
                    endcase
                end
            end else if (state_reg != ST_IDLE) begin
                if (tmo_cnt_reg == TMO_LAST) begin
                    state_reg   <= ST_IDLE;
                    tmo_cnt_reg <= '0;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign ctl_strobe = ctl_strobe_reg;
    assign ctl_byte   = ctl_byte_reg;
    assign overflow   = overflow_reg;

endmodule
